// File: rtl/reqrsp_pkg.sv
// Shared reqrsp types plus helpers for the AMO shim and its ALU.
package reqrsp_pkg;

   typedef logic [2:0] size_t;

   typedef enum logic [3:0] {
      AMONone = 4'h0,
      AMOSwap = 4'h1,
      AMOAdd  = 4'h2,
      AMOAnd  = 4'h3,
      AMOOr   = 4'h4,
      AMOXor  = 4'h5,
      AMOMax  = 4'h6,
      AMOMaxu = 4'h7,
      AMOMin  = 4'h8,
      AMOMinu = 4'h9,
      AMOLR   = 4'hA,
      AMOSC   = 4'hB
   } amo_op_e;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_WAIT,
      RESP
   } amo_shim_state_e;

   // True for the read-modify-write atomics (LR/SC handled separately).
   function automatic logic is_amo(input amo_op_e op);
      return (op == AMOSwap) || (op == AMOAdd) || (op == AMOAnd) || (op == AMOOr) ||
             (op == AMOXor) || (op == AMOMax) || (op == AMOMaxu) || (op == AMOMin) ||
             (op == AMOMinu);
   endfunction

   // Select the 32-bit lane of a 64-bit beat.
   function automatic logic [31:0] lane_word(input logic [63:0] data, input logic lane);
      return lane ? data[63:32] : data[31:0];
   endfunction

   // Sign-extend a word to 64 bits.
   function automatic logic [63:0] sext_word(input logic [31:0] w);
      return {{32{w[31]}}, w};
   endfunction

   // Byte enables covering the atomic's lane (word) or the whole beat (double).
   function automatic logic [7:0] atomic_be(input size_t size, input logic lane);
      if (size == 3'd3) return 8'hFF;
      return lane ? 8'hF0 : 8'h0F;
   endfunction

endpackage

// File: rtl/reqrsp_amo_alu.sv
// Combinational AMO datapath: computes the value written back for an atomic.
module reqrsp_amo_alu
   import reqrsp_pkg::*;
(
   input  amo_op_e     amo,
   input  size_t       size,
   input  logic        lane,
   input  logic [63:0] old_data,
   input  logic [63:0] operand,
   output logic [63:0] result_c
);

   logic [63:0] a_s, b_s, a_u, b_u, res;
   logic        lt_s, lt_u;

   // Word ops work on the addressed lane of both old value and operand; result is replicated.
   always_comb begin
      if (size == 3'd3) begin
         a_s = old_data;
         b_s = operand;
         a_u = old_data;
         b_u = operand;
      end else begin
         a_s = sext_word(lane_word(old_data, lane));
         b_s = sext_word(lane_word(operand, lane));
         a_u = {32'b0, lane_word(old_data, lane)};
         b_u = {32'b0, lane_word(operand, lane)};
      end
      lt_s = $signed(a_s) < $signed(b_s);
      lt_u = a_u < b_u;
      case (amo)
         AMOAdd:  res = a_u + b_u;
         AMOAnd:  res = a_u & b_u;
         AMOOr:   res = a_u | b_u;
         AMOXor:  res = a_u ^ b_u;
         AMOMax:  res = lt_s ? b_u : a_u;
         AMOMaxu: res = lt_u ? b_u : a_u;
         AMOMin:  res = lt_s ? a_u : b_u;
         AMOMinu: res = lt_u ? a_u : b_u;
         default: res = b_u;
      endcase
      result_c = (size == 3'd3) ? res : {2{res[31:0]}};
   end

endmodule

// File: rtl/reqrsp_amo_shim.sv
// Executes reqrsp atomics (incl. LR/SC) as read-modify-write on a plain single-port memory.
module reqrsp_amo_shim
   import reqrsp_pkg::*;
#(
   parameter int unsigned AddrWidth = 48,
   parameter int unsigned DataWidth = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [AddrWidth-1:0]   in_q_addr_i,
   input  logic                   in_q_write_i,
   input  amo_op_e                in_q_amo_i,
   input  logic [DataWidth-1:0]   in_q_data_i,
   input  logic [DataWidth/8-1:0] in_q_strb_i,
   input  size_t                  in_q_size_i,
   input  logic                   in_q_valid_i,
   output logic                   in_q_ready_o,
   output logic [DataWidth-1:0]   in_p_data_o,
   output logic                   in_p_error_o,
   output logic                   in_p_valid_o,
   input  logic                   in_p_ready_i,
   output logic                   mem_req_o,
   input  logic                   mem_gnt_i,
   output logic                   mem_we_o,
   output logic [AddrWidth-1:0]   mem_addr_o,
   output logic [DataWidth-1:0]   mem_wdata_o,
   output logic [DataWidth/8-1:0] mem_be_o,
   input  logic                   mem_rvalid_i,
   input  logic [DataWidth-1:0]   mem_rdata_i
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned TagWidth  = AddrWidth - 3;

   amo_shim_state_e      state_q;
   amo_op_e              req_amo_q;
   size_t                req_size_q;
   logic                 req_write_q;
   logic                 req_lane_q;
   logic [TagWidth-1:0]  req_tag_q;
   logic [DataWidth-1:0] req_data_q;
   logic                 resv_valid_q;
   logic [TagWidth-1:0]  resv_tag_q;

   logic                 atomic_c, size_bad_c, misaligned_c, req_bad_c, sc_hit_c, resv_hit_c;
   logic [DataWidth-1:0] sc_wdata_c, old_resp_c, alu_result_c;

   // Request decode: error classification, SC reservation check, SC write data.
   always_comb begin
      atomic_c     = (in_q_amo_i != AMONone);
      size_bad_c   = (in_q_size_i > 3'd3) || (atomic_c && (in_q_size_i < 3'd2));
      misaligned_c = atomic_c &&
                     (((in_q_size_i == 3'd2) && (in_q_addr_i[1:0] != 2'b00)) ||
                      ((in_q_size_i == 3'd3) && (in_q_addr_i[2:0] != 3'b000)));
      req_bad_c    = size_bad_c || misaligned_c;
      sc_hit_c     = resv_valid_q && (resv_tag_q == in_q_addr_i[AddrWidth-1:3]);
      resv_hit_c   = resv_valid_q && (resv_tag_q == req_tag_q);
      sc_wdata_c   = (in_q_size_i == 3'd3) ? in_q_data_i
                                           : {2{lane_word(in_q_data_i, in_q_addr_i[2])}};
      old_resp_c   = (req_size_q == 3'd3) ? mem_rdata_i
                                          : sext_word(lane_word(mem_rdata_i, req_lane_q));
   end

   reqrsp_amo_alu i_alu (
      .amo      (req_amo_q),
      .size     (req_size_q),
      .lane     (req_lane_q),
      .old_data (mem_rdata_i),
      .operand  (req_data_q),
      .result_c (alu_result_c)
   );

   // Transaction FSM with registered handshake, memory command and response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         req_amo_q    <= AMONone;
         req_size_q   <= 3'd0;
         req_write_q  <= 1'b0;
         req_lane_q   <= 1'b0;
         req_tag_q    <= '0;
         req_data_q   <= '0;
         resv_valid_q <= 1'b0;
         resv_tag_q   <= '0;
         in_q_ready_o <= 1'b0;
         in_p_data_o  <= '0;
         in_p_error_o <= 1'b0;
         in_p_valid_o <= 1'b0;
         mem_req_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
         mem_be_o     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               in_q_ready_o <= 1'b1;
               if (in_q_valid_i && in_q_ready_o) begin
                  in_q_ready_o <= 1'b0;
                  req_amo_q    <= in_q_amo_i;
                  req_size_q   <= in_q_size_i;
                  req_write_q  <= in_q_write_i && !atomic_c;
                  req_lane_q   <= in_q_addr_i[2];
                  req_tag_q    <= in_q_addr_i[AddrWidth-1:3];
                  req_data_q   <= in_q_data_i;
                  mem_addr_o   <= in_q_addr_i;
                  in_p_data_o  <= '0;
                  if (req_bad_c) begin
                     state_q      <= RESP;
                     in_p_valid_o <= 1'b1;
                     in_p_error_o <= 1'b1;
                  end else if (in_q_amo_i == AMOSC) begin
                     resv_valid_q <= 1'b0;
                     if (sc_hit_c) begin
                        state_q     <= WR_REQ;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_wdata_o <= sc_wdata_c;
                        mem_be_o    <= atomic_be(in_q_size_i, in_q_addr_i[2]);
                     end else begin
                        state_q      <= RESP;
                        in_p_valid_o <= 1'b1;
                        in_p_data_o  <= DataWidth'(1);
                     end
                  end else begin
                     state_q   <= RD_REQ;
                     mem_req_o <= 1'b1;
                     if (in_q_write_i && !atomic_c) begin
                        mem_we_o    <= 1'b1;
                        mem_wdata_o <= in_q_data_i;
                        mem_be_o    <= in_q_strb_i;
                     end else begin
                        mem_we_o    <= 1'b0;
                        mem_wdata_o <= '0;
                        mem_be_o    <= {StrbWidth{1'b1}};
                     end
                  end
               end
            end
            RD_REQ: begin
               if (mem_gnt_i) begin
                  state_q   <= RD_WAIT;
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  if (req_write_q && resv_hit_c) resv_valid_q <= 1'b0;
               end
            end
            RD_WAIT: begin
               if (mem_rvalid_i) begin
                  if (is_amo(req_amo_q)) begin
                     state_q     <= WR_REQ;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= 1'b1;
                     mem_wdata_o <= alu_result_c;
                     mem_be_o    <= atomic_be(req_size_q, req_lane_q);
                     in_p_data_o <= old_resp_c;
                  end else begin
                     state_q      <= RESP;
                     in_p_valid_o <= 1'b1;
                     if (req_amo_q == AMOLR) begin
                        in_p_data_o  <= old_resp_c;
                        resv_valid_q <= 1'b1;
                        resv_tag_q   <= req_tag_q;
                     end else if (req_write_q) begin
                        in_p_data_o <= '0;
                     end else begin
                        in_p_data_o <= mem_rdata_i;
                     end
                  end
               end
            end
            WR_REQ: begin
               if (mem_gnt_i) begin
                  state_q   <= WR_WAIT;
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  if (resv_hit_c) resv_valid_q <= 1'b0;
               end
            end
            WR_WAIT: begin
               if (mem_rvalid_i) begin
                  state_q      <= RESP;
                  in_p_valid_o <= 1'b1;
               end
            end
            RESP: begin
               if (in_p_ready_i) begin
                  state_q      <= IDLE;
                  in_p_valid_o <= 1'b0;
                  in_p_error_o <= 1'b0;
                  in_p_data_o  <= '0;
                  in_q_ready_o <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reqrsp_amo_shim.sv
// Directed bench for reqrsp_amo_shim with a grant/rvalid memory model.
module tb_reqrsp_amo_shim;
   import reqrsp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [47:0] in_q_addr_i;
   logic        in_q_write_i;
   amo_op_e     in_q_amo_i;
   logic [63:0] in_q_data_i;
   logic [7:0]  in_q_strb_i;
   size_t       in_q_size_i;
   logic        in_q_valid_i;
   logic        in_q_ready_o;
   logic [63:0] in_p_data_o;
   logic        in_p_error_o;
   logic        in_p_valid_o;
   logic        in_p_ready_i;
   logic        mem_req_o;
   logic        mem_gnt_i;
   logic        mem_we_o;
   logic [47:0] mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_be_o;
   logic        mem_rvalid_i;
   logic [63:0] mem_rdata_i;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   reqrsp_amo_shim dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .in_q_addr_i  (in_q_addr_i),
      .in_q_write_i (in_q_write_i),
      .in_q_amo_i   (in_q_amo_i),
      .in_q_data_i  (in_q_data_i),
      .in_q_strb_i  (in_q_strb_i),
      .in_q_size_i  (in_q_size_i),
      .in_q_valid_i (in_q_valid_i),
      .in_q_ready_o (in_q_ready_o),
      .in_p_data_o  (in_p_data_o),
      .in_p_error_o (in_p_error_o),
      .in_p_valid_o (in_p_valid_o),
      .in_p_ready_i (in_p_ready_i),
      .mem_req_o    (mem_req_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_be_o     (mem_be_o),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   // Memory model: grant while enabled, rvalid one cycle after grant, byte-enabled writes.
   logic [63:0] mem [0:127];
   logic        gnt_en = 1'b1;
   logic        bd_we  = 1'b0;
   logic [6:0]  bd_idx = '0;
   logic [63:0] bd_data = '0;
   logic        rvalid_q = 1'b0;
   logic [63:0] rdata_q = '0;
   logic [63:0] last_wdata = '0;
   logic [7:0]  last_be = '0;
   int          gnt_count = 0;

   assign mem_gnt_i    = mem_req_o & gnt_en;
   assign mem_rvalid_i = rvalid_q;
   assign mem_rdata_i  = rdata_q;

   always_ff @(posedge clk) begin
      rvalid_q <= 1'b0;
      if (bd_we) mem[bd_idx] <= bd_data;
      if (mem_req_o && mem_gnt_i) begin
         rvalid_q  <= 1'b1;
         gnt_count <= gnt_count + 1;
         if (mem_we_o) begin
            for (int b = 0; b < 8; b++)
               if (mem_be_o[b]) mem[mem_addr_o[9:3]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
            last_wdata <= mem_wdata_o;
            last_be    <= mem_be_o;
         end else begin
            rdata_q <= mem[mem_addr_o[9:3]];
         end
      end
   end

   task automatic poke(input logic [47:0] addr, input logic [63:0] data);
      bd_idx  = addr[9:3];
      bd_data = data;
      bd_we   = 1'b1;
      @(posedge clk); #1;
      bd_we   = 1'b0;
   endtask

   function automatic logic [63:0] peek(input logic [47:0] addr);
      return mem[addr[9:3]];
   endfunction

   // Issue one request and collect its response; lat counts cycles from accept to resp valid.
   task automatic do_req(input logic [47:0] addr, input logic wr, input amo_op_e amo,
                         input logic [63:0] data, input logic [7:0] strb, input size_t size,
                         output logic [63:0] rdata, output logic err, output int lat);
      int n;
      n = 0;
      while (in_q_ready_o !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      in_q_addr_i  = addr;
      in_q_write_i = wr;
      in_q_amo_i   = amo;
      in_q_data_i  = data;
      in_q_strb_i  = strb;
      in_q_size_i  = size;
      in_q_valid_i = 1'b1;
      @(posedge clk); #1;
      in_q_valid_i = 1'b0;
      lat = 1;
      while (in_p_valid_o !== 1'b1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = in_p_data_o;
      err   = in_p_error_o;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (in_q_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %b want 0", in_q_ready_o);
      end
      n_checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, in_p_valid_o, in_p_error_o} !== 12'h000) begin
         n_fail++; $display("FAIL reset_outputs: req=%b we=%b be=%h pv=%b perr=%b want all 0",
                            mem_req_o, mem_we_o, mem_be_o, in_p_valid_o, in_p_error_o);
      end
      n_checks++;
      if (in_p_data_o !== 64'h0) begin
         n_fail++; $display("FAIL reset_pdata: got %h want 0", in_p_data_o);
      end
      rst_i = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (in_q_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL idle_ready: got %b want 1", in_q_ready_o);
      end
   endtask

   task automatic test_load();
      logic [63:0] d; logic e; int lat;
      poke(48'h100, 64'h1122334455667788);
      do_req(48'h100, 1'b0, AMONone, 64'h0, 8'h00, 3'd3, d, e, lat);
      n_checks++;
      if (d !== 64'h1122334455667788 || e !== 1'b0) begin
         n_fail++; $display("FAIL load_data: got %h err %b want 1122334455667788 err 0", d, e);
      end
      n_checks++;
      if (lat != 3) begin
         n_fail++; $display("FAIL load_latency: got %0d want 3", lat);
      end
   endtask

   task automatic test_amo_add();
      logic [63:0] d; logic e; int lat;
      poke(48'h100, 64'hFFFFFFFF_00000000);
      do_req(48'h104, 1'b0, AMOAdd, {2{32'h1}}, 8'h00, 3'd2, d, e, lat);
      n_checks++;
      if (d !== 64'hFFFFFFFFFFFFFFFF || e !== 1'b0) begin
         n_fail++; $display("FAIL amoadd_resp: got %h err %b want ffffffffffffffff err 0", d, e);
      end
      n_checks++;
      if (last_be !== 8'hF0 || last_wdata[63:32] !== 32'h0) begin
         n_fail++; $display("FAIL amoadd_write: be %h wdata %h want be f0 upper 0", last_be, last_wdata);
      end
      n_checks++;
      if (peek(48'h100) !== 64'h0) begin
         n_fail++; $display("FAIL amoadd_mem: got %h want 0", peek(48'h100));
      end
      n_checks++;
      if (lat != 5) begin
         n_fail++; $display("FAIL amo_latency: got %0d want 5", lat);
      end
   endtask

   task automatic test_amo_minmax();
      logic [63:0] d; logic e; int lat;
      poke(48'h100, 64'h00000000_00000005);
      do_req(48'h100, 1'b0, AMOMin, {2{32'hFFFFFFFE}}, 8'h00, 3'd2, d, e, lat);
      n_checks++;
      if (d !== 64'h5 || last_wdata[31:0] !== 32'hFFFFFFFE || last_be !== 8'h0F) begin
         n_fail++; $display("FAIL amomin: resp %h wdata %h be %h want 5 fffffffe 0f", d, last_wdata, last_be);
      end
      n_checks++;
      if (peek(48'h100) !== 64'h00000000_FFFFFFFE) begin
         n_fail++; $display("FAIL amomin_mem: got %h want 00000000fffffffe", peek(48'h100));
      end
      poke(48'h100, 64'h00000000_00000005);
      do_req(48'h100, 1'b0, AMOMinu, {2{32'hFFFFFFFE}}, 8'h00, 3'd2, d, e, lat);
      n_checks++;
      if (d !== 64'h5 || last_wdata[31:0] !== 32'h00000005) begin
         n_fail++; $display("FAIL amominu: resp %h wdata %h want 5 00000005", d, last_wdata);
      end
      poke(48'h108, 64'h8000000000000000);
      do_req(48'h108, 1'b0, AMOMax, 64'h1, 8'h00, 3'd3, d, e, lat);
      n_checks++;
      if (d !== 64'h8000000000000000 || peek(48'h108) !== 64'h1 || last_be !== 8'hFF) begin
         n_fail++; $display("FAIL amomax_d: resp %h mem %h be %h want 8000000000000000 1 ff",
                            d, peek(48'h108), last_be);
      end
      do_req(48'h108, 1'b0, AMOMaxu, 64'h8000000000000000, 8'h00, 3'd3, d, e, lat);
      n_checks++;
      if (d !== 64'h1 || peek(48'h108) !== 64'h8000000000000000) begin
         n_fail++; $display("FAIL amomaxu_d: resp %h mem %h want 1 8000000000000000", d, peek(48'h108));
      end
   endtask

   task automatic test_lr_sc();
      logic [63:0] d; logic e; int lat; int g0;
      poke(48'h200, 64'h55);
      do_req(48'h200, 1'b0, AMOLR, 64'h0, 8'h00, 3'd3, d, e, lat);
      n_checks++;
      if (d !== 64'h55 || lat != 3) begin
         n_fail++; $display("FAIL lr: resp %h lat %0d want 55 lat 3", d, lat);
      end
      do_req(48'h200, 1'b0, AMOSC, 64'h7, 8'h00, 3'd3, d, e, lat);
      n_checks++;
      if (d !== 64'h0 || e !== 1'b0 || peek(48'h200) !== 64'h7) begin
         n_fail++; $display("FAIL sc_pass: resp %h err %b mem %h want 0 0 7", d, e, peek(48'h200));
      end
      g0 = gnt_count;
      do_req(48'h200, 1'b0, AMOSC, 64'h9, 8'h00, 3'd3, d, e, lat);
      n_checks++;
      if (d !== 64'h1 || gnt_count != g0 || peek(48'h200) !== 64'h7) begin
         n_fail++; $display("FAIL sc_fail: resp %h grants %0d mem %h want 1 0 7",
                            d, gnt_count - g0, peek(48'h200));
      end
   endtask

   task automatic test_resv_clear_and_errors();
      logic [63:0] d; logic e; int lat; int g0;
      poke(48'h200, 64'h0);
      do_req(48'h200, 1'b0, AMOLR, 64'h0, 8'h00, 3'd3, d, e, lat);
      do_req(48'h204, 1'b1, AMONone, 64'hAAAABBBB_00000000, 8'hF0, 3'd2, d, e, lat);
      n_checks++;
      if (d !== 64'h0 || peek(48'h200) !== 64'hAAAABBBB_00000000 || lat != 3) begin
         n_fail++; $display("FAIL store: resp %h mem %h lat %0d want 0 aaaabbbb00000000 3",
                            d, peek(48'h200), lat);
      end
      do_req(48'h200, 1'b0, AMOSC, 64'h3, 8'h00, 3'd3, d, e, lat);
      n_checks++;
      if (d !== 64'h1 || peek(48'h200) !== 64'hAAAABBBB_00000000) begin
         n_fail++; $display("FAIL sc_after_store: resp %h mem %h want 1 unchanged", d, peek(48'h200));
      end
      g0 = gnt_count;
      do_req(48'h102, 1'b0, AMOSwap, 64'h0, 8'h00, 3'd2, d, e, lat);
      n_checks++;
      if (e !== 1'b1 || d !== 64'h0 || gnt_count != g0) begin
         n_fail++; $display("FAIL misaligned_err: err %b data %h grants %0d want 1 0 0", e, d, gnt_count - g0);
      end
      do_req(48'h100, 1'b0, AMOAdd, 64'h0, 8'h00, 3'd1, d, e, lat);
      n_checks++;
      if (e !== 1'b1 || gnt_count != g0) begin
         n_fail++; $display("FAIL amo_size_err: err %b grants %0d want 1 0", e, gnt_count - g0);
      end
      do_req(48'h100, 1'b0, AMONone, 64'h0, 8'h00, 3'd4, d, e, lat);
      n_checks++;
      if (e !== 1'b1 || gnt_count != g0) begin
         n_fail++; $display("FAIL big_size_err: err %b grants %0d want 1 0", e, gnt_count - g0);
      end
      do_req(48'h102, 1'b0, AMONone, 64'h0, 8'h00, 3'd1, d, e, lat);
      n_checks++;
      if (e !== 1'b0) begin
         n_fail++; $display("FAIL plain_unaligned: err %b want 0", e);
      end
   endtask

   task automatic test_stall();
      int n;
      poke(48'h110, 64'hCAFEF00D_12345678);
      gnt_en       = 1'b0;
      in_p_ready_i = 1'b0;
      in_q_addr_i  = 48'h110;
      in_q_write_i = 1'b0;
      in_q_amo_i   = AMONone;
      in_q_size_i  = 3'd3;
      in_q_valid_i = 1'b1;
      @(posedge clk); #1;
      in_q_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (mem_req_o !== 1'b1 || mem_addr_o !== 48'h110 || mem_we_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_cmd: cyc %0d req %b addr %h we %b want 1 110 0",
                               i, mem_req_o, mem_addr_o, mem_we_o);
         end
         @(posedge clk); #1;
      end
      gnt_en = 1'b1;
      n = 0;
      while (in_p_valid_o !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (in_p_valid_o !== 1'b1 || in_p_data_o !== 64'hCAFEF00D_12345678) begin
            n_fail++; $display("FAIL stall_resp: cyc %0d valid %b data %h want 1 cafef00d12345678",
                               i, in_p_valid_o, in_p_data_o);
         end
         @(posedge clk); #1;
      end
      in_p_ready_i = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (in_p_valid_o !== 1'b0 || in_q_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL stall_release: valid %b ready %b want 0 1", in_p_valid_o, in_q_ready_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] d; logic e; int lat;
      do_req(48'h200, 1'b0, AMOLR, 64'h0, 8'h00, 3'd3, d, e, lat);
      in_q_addr_i  = 48'h100;
      in_q_amo_i   = AMONone;
      in_q_write_i = 1'b0;
      in_q_size_i  = 3'd3;
      in_q_valid_i = 1'b1;
      @(posedge clk); #1;
      in_q_valid_i = 1'b0;
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (in_p_valid_o !== 1'b0 || mem_req_o !== 1'b0 || in_q_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL midreset: pvalid %b req %b ready %b want 0 0 0",
                            in_p_valid_o, mem_req_o, in_q_ready_o);
      end
      rst_i = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (in_q_ready_o !== 1'b1 || in_p_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL midreset_idle: ready %b pvalid %b want 1 0", in_q_ready_o, in_p_valid_o);
      end
      do_req(48'h200, 1'b0, AMOSC, 64'h5, 8'h00, 3'd3, d, e, lat);
      n_checks++;
      if (d !== 64'h1) begin
         n_fail++; $display("FAIL midreset_resv: sc resp %h want 1", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] d; logic e; int lat;
      poke(48'h118, 64'h0123456789ABCDEF);
      do_req(48'h118, 1'b0, AMOXor, {2{32'hFFFFFFFF}}, 8'h00, 3'd2, d, e, lat);
      do_req(48'h118, 1'b0, AMONone, 64'h0, 8'h00, 3'd3, d, e, lat);
      n_checks++;
      if (d !== 64'h01234567_76543210) begin
         n_fail++; $display("FAIL b2b_xor: got %h want 0123456776543210", d);
      end
   endtask

   initial begin
      rst_i        = 1'b1;
      in_q_addr_i  = '0;
      in_q_write_i = 1'b0;
      in_q_amo_i   = AMONone;
      in_q_data_i  = '0;
      in_q_strb_i  = '0;
      in_q_size_i  = 3'd0;
      in_q_valid_i = 1'b0;
      in_p_ready_i = 1'b1;
      test_reset();
      test_load();
      test_amo_add();
      test_amo_minmax();
      test_lr_sc();
      test_resv_clear_and_errors();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
